dram_seq: RTL and testbench

DRAM cycle sequencer that consumes the clock generator's 500 ns memory-cycle strobes and drives the DRAM control pins. It locks a local 16-step phase counter onto `cycsel_en`, splits each period into a CPU slot and a video/refresh slot, and arbitrates CPU, video and refresh accesses. It sits between the clock generator and the DRAM pads, beside the address multiplexer, which it steers through `mux_col`.

---
 rtl/dram_seq_pkg.sv | 28 ++
 rtl/dram_phase_lock.sv | 62 ++++++
 rtl/dram_seq.sv | 210 +++++++++++++++++++++
 tb/tb_dram_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_seq_pkg.sv
// dram_seq_pkg: shared types and constants for the DRAM cycle sequencer.
//   lock_state_e : phase-lock FSM states
//   grant_e      : owner of the current 8-step slot
//   step constants: slot step (ph[2:0]) at which each strobe changes
package dram_seq_pkg;

   typedef enum logic [1:0] {
      LockHunt,
      LockCheck,
      LockLocked
   } lock_state_e;

   typedef enum logic [1:0] {
      GntNone,
      GntCpu,
      GntVid,
      GntRef
   } grant_e;

   localparam logic [2:0] RasOn     = 3'd1;
   localparam logic [2:0] WeOn      = 3'd2;
   localparam logic [2:0] ColOn     = 3'd3;
   localparam logic [2:0] CasOn     = 3'd4;
   localparam logic [2:0] RefOff    = 3'd5;
   localparam logic [2:0] AckS      = 3'd6;
   localparam logic [2:0] StrobeOff = 3'd7;

endpackage

// File: rtl/dram_phase_lock.sv
// dram_phase_lock: locks a 16-step phase counter onto the cycsel_en strobe.
//   clk_i        : 32 MHz clock
//   rst_ni       : synchronous active-low reset
//   cycsel_en_i  : strobe expected in the cycle where ph = 15
//   ph_o         : current phase (0..15)
//   step_nxt_o   : slot step the phase will hold after the next edge
//   locked_o     : FSM currently LOCKED
//   locked_nxt_o : FSM will be LOCKED after the next edge
module dram_phase_lock
   import dram_seq_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       cycsel_en_i,
   output logic [3:0] ph_o,
   output logic [2:0] step_nxt_o,
   output logic       locked_o,
   output logic       locked_nxt_o
);

   lock_state_e st_q, st_d;
   logic [3:0]  ph_q, ph_d;

   always_comb begin
      st_d = st_q;
      ph_d = ph_q + 4'd1;
      unique case (st_q)
         LockHunt: begin
            if (cycsel_en_i) begin
               st_d = LockCheck;
               ph_d = '0;
            end
         end
         LockCheck, LockLocked: begin
            // At ph = 15 the counter wraps to 0 by itself; only the verdict changes.
            if (ph_q == 4'd15) begin
               st_d = cycsel_en_i ? LockLocked : LockHunt;
            end else if (cycsel_en_i) begin
               st_d = LockCheck;
               ph_d = '0;
            end
         end
         default: st_d = LockHunt;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         st_q <= LockHunt;
         ph_q <= '0;
      end else begin
         st_q <= st_d;
         ph_q <= ph_d;
      end
   end

   assign ph_o         = ph_q;
   assign step_nxt_o   = ph_d[2:0];
   assign locked_o     = (st_q == LockLocked);
   assign locked_nxt_o = (st_d == LockLocked);

endmodule

// File: rtl/dram_seq.sv
// dram_seq: DRAM cycle sequencer. Splits each 16-clock memory cycle into a CPU
// slot (ph 0-7) and a video/refresh slot (ph 8-15), arbitrates, and drives the
// DRAM control pins with registered strobes.
//   clk32, resb          : clock, synchronous active-low reset
//   cycsel_en            : phase strobe from the clock generator
//   cpu_req/rw/bank/uds/lds, vid_req/vid_bank : access requests
//   ras_n, cash_n, casl_n, we_n, mux_col      : DRAM pins / address mux steer
//   cpu_ack, vid_ack, ref_active, locked      : status
module dram_seq
   import dram_seq_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 60,
   parameter int unsigned STARVE_MAX  = 8
) (
   input  logic       clk32,
   input  logic       resb,
   input  logic       cycsel_en,
   input  logic       cpu_req,
   input  logic       cpu_rw,
   input  logic       cpu_bank,
   input  logic       cpu_uds,
   input  logic       cpu_lds,
   input  logic       vid_req,
   input  logic       vid_bank,
   output logic [1:0] ras_n,
   output logic [1:0] cash_n,
   output logic [1:0] casl_n,
   output logic       we_n,
   output logic       mux_col,
   output logic       cpu_ack,
   output logic       vid_ack,
   output logic       ref_active,
   output logic       locked
);

   localparam int unsigned RefW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [2:0]  StarveLim = 3'(STARVE_MAX - 1);

   logic [3:0] ph;
   logic [2:0] s_nxt;
   logic       locked_now, locked_nxt;

   dram_phase_lock u_phase_lock (
      .clk_i        (clk32),
      .rst_ni       (resb),
      .cycsel_en_i  (cycsel_en),
      .ph_o         (ph),
      .step_nxt_o   (s_nxt),
      .locked_o     (locked_now),
      .locked_nxt_o (locked_nxt)
   );

   grant_e          gnt_q, gnt_d;
   logic            bank_q, bank_d, rw_q, rw_d, uds_q, uds_d, lds_q, lds_d;
   logic [RefW-1:0] ref_cnt_q, ref_cnt_d;
   logic            ref_pend_q, ref_pend_d;
   logic [2:0]      starve_q, starve_d;
   logic [1:0]      ras_n_q, ras_n_d, cash_n_q, cash_n_d, casl_n_q, casl_n_d;
   logic            we_n_q, we_n_d, mux_col_q, mux_col_d;
   logic            cpu_ack_q, cpu_ack_d, vid_ack_q, vid_ack_d, ref_active_q, ref_active_d;

   logic slot_edge, cpu_edge, ref_wrap, ref_take;

   assign cpu_edge  = (ph == 4'd15);
   assign slot_edge = locked_now && (cpu_edge || ph == 4'd7);

   // Arbitration and refresh bookkeeping.
   always_comb begin
      gnt_d      = gnt_q;
      bank_d     = bank_q;
      rw_d       = rw_q;
      uds_d      = uds_q;
      lds_d      = lds_q;
      ref_cnt_d  = ref_cnt_q;
      starve_d   = starve_q;
      ref_wrap   = 1'b0;
      ref_take   = 1'b0;

      if (slot_edge) begin
         if (ref_cnt_q == RefW'(REFRESH_DIV - 1)) begin
            ref_cnt_d = '0;
            ref_wrap  = 1'b1;
         end else begin
            ref_cnt_d = ref_cnt_q + RefW'(1);
         end
      end

      if (cpu_edge || ph == 4'd7) begin
         gnt_d = GntNone;
      end

      // A grant needs the lock both before and after the sampling edge.
      if (slot_edge && locked_nxt) begin
         if (cpu_edge) begin
            if (cpu_req) begin
               gnt_d  = GntCpu;
               bank_d = cpu_bank;
               rw_d   = cpu_rw;
               uds_d  = cpu_uds;
               lds_d  = cpu_lds;
            end
         end else if (ref_pend_q && (!vid_req || starve_q == StarveLim)) begin
            gnt_d    = GntRef;
            ref_take = 1'b1;
            starve_d = '0;
         end else begin
            if (vid_req) begin
               gnt_d  = GntVid;
               bank_d = vid_bank;
               rw_d   = 1'b1;
               uds_d  = 1'b1;
               lds_d  = 1'b1;
            end
            if (ref_pend_q) begin
               starve_d = starve_q + 3'd1;
            end
         end
      end

      if (!locked_nxt) begin
         gnt_d = GntNone;
      end

      // A fresh wrap wins over a same-edge grant: a new interval has elapsed.
      ref_pend_d = ref_wrap ? 1'b1 : (ref_take ? 1'b0 : ref_pend_q);
   end

   // Strobe values for the step the counter enters on this edge.
   always_comb begin
      ras_n_d      = 2'b11;
      cash_n_d     = 2'b11;
      casl_n_d     = 2'b11;
      we_n_d       = 1'b1;
      mux_col_d    = 1'b0;
      cpu_ack_d    = 1'b0;
      vid_ack_d    = 1'b0;
      ref_active_d = 1'b0;
      unique case (gnt_d)
         GntCpu, GntVid: begin
            if (s_nxt >= RasOn && s_nxt < StrobeOff) ras_n_d[bank_d] = 1'b0;
            if (s_nxt >= ColOn && s_nxt < StrobeOff) mux_col_d = 1'b1;
            if (!rw_d && s_nxt >= WeOn && s_nxt < StrobeOff) we_n_d = 1'b0;
            if (s_nxt >= CasOn && s_nxt < StrobeOff) begin
               cash_n_d[bank_d] = ~uds_d;
               casl_n_d[bank_d] = ~lds_d;
            end
            if (s_nxt == AckS) begin
               cpu_ack_d = (gnt_d == GntCpu);
               vid_ack_d = (gnt_d == GntVid);
            end
         end
         GntRef: begin
            if (s_nxt >= RasOn && s_nxt <= RefOff) begin
               ras_n_d      = 2'b00;
               ref_active_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk32) begin
      if (!resb) begin
         gnt_q        <= GntNone;
         bank_q       <= 1'b0;
         rw_q         <= 1'b1;
         uds_q        <= 1'b0;
         lds_q        <= 1'b0;
         ref_cnt_q    <= '0;
         ref_pend_q   <= 1'b0;
         starve_q     <= '0;
         ras_n_q      <= 2'b11;
         cash_n_q     <= 2'b11;
         casl_n_q     <= 2'b11;
         we_n_q       <= 1'b1;
         mux_col_q    <= 1'b0;
         cpu_ack_q    <= 1'b0;
         vid_ack_q    <= 1'b0;
         ref_active_q <= 1'b0;
      end else begin
         gnt_q        <= gnt_d;
         bank_q       <= bank_d;
         rw_q         <= rw_d;
         uds_q        <= uds_d;
         lds_q        <= lds_d;
         ref_cnt_q    <= ref_cnt_d;
         ref_pend_q   <= ref_pend_d;
         starve_q     <= starve_d;
         ras_n_q      <= ras_n_d;
         cash_n_q     <= cash_n_d;
         casl_n_q     <= casl_n_d;
         we_n_q       <= we_n_d;
         mux_col_q    <= mux_col_d;
         cpu_ack_q    <= cpu_ack_d;
         vid_ack_q    <= vid_ack_d;
         ref_active_q <= ref_active_d;
      end
   end

   assign ras_n      = ras_n_q;
   assign cash_n     = cash_n_q;
   assign casl_n     = casl_n_q;
   assign we_n       = we_n_q;
   assign mux_col    = mux_col_q;
   assign cpu_ack    = cpu_ack_q;
   assign vid_ack    = vid_ack_q;
   assign ref_active = ref_active_q;
   assign locked     = locked_now;

endmodule

// File: tb/tb_dram_seq.sv
// tb_dram_seq: directed, self-checking bench for dram_seq (REFRESH_DIV = 4).
// Output vector layout: {ras_n, cash_n, casl_n, we_n, mux_col,
//                        cpu_ack, vid_ack, ref_active, locked}
module tb_dram_seq;

   logic       clk32;
   logic       resb, cycsel_en, cpu_req, cpu_rw, cpu_bank, cpu_uds, cpu_lds;
   logic       vid_req, vid_bank;
   logic [1:0] ras_n, cash_n, casl_n;
   logic       we_n, mux_col, cpu_ack, vid_ack, ref_active, locked;
   logic [11:0] outs;

   int checks = 0;
   int errors = 0;
   int tb_ph  = 0;
   bit auto_cyc = 1'b0;
   bit inj      = 1'b0;

   localparam logic [11:0] RstVal  = 12'hFE0;
   localparam logic [11:0] IdleLck = 12'hFE1;

   initial clk32 = 1'b0;
   always #5 clk32 = ~clk32;

   dram_seq #(
      .REFRESH_DIV (4),
      .STARVE_MAX  (8)
   ) dut (
      .clk32      (clk32),
      .resb       (resb),
      .cycsel_en  (cycsel_en),
      .cpu_req    (cpu_req),
      .cpu_rw     (cpu_rw),
      .cpu_bank   (cpu_bank),
      .cpu_uds    (cpu_uds),
      .cpu_lds    (cpu_lds),
      .vid_req    (vid_req),
      .vid_bank   (vid_bank),
      .ras_n      (ras_n),
      .cash_n     (cash_n),
      .casl_n     (casl_n),
      .we_n       (we_n),
      .mux_col    (mux_col),
      .cpu_ack    (cpu_ack),
      .vid_ack    (vid_ack),
      .ref_active (ref_active),
      .locked     (locked)
   );

   assign outs = {ras_n, cash_n, casl_n, we_n, mux_col, cpu_ack, vid_ack, ref_active, locked};

   // One clock; cycsel_en is emitted at the expected phase or when injected.
   task automatic tick();
      cycsel_en = inj || (auto_cyc && tb_ph == 15);
      @(posedge clk32);
      #1;
      if (!resb || cycsel_en) tb_ph = 0;
      else tb_ph = (tb_ph + 1) % 16;
      inj = 1'b0;
      cycsel_en = 1'b0;
   endtask

   task automatic test_reset();
      resb = 1'b0;
      tick();
      checks++;
      if (outs !== RstVal) begin
         errors++;
         $display("FAIL reset_1 got %h exp %h", outs, RstVal);
      end
      tick();
      checks++;
      if (outs !== RstVal) begin
         errors++;
         $display("FAIL reset_2 got %h exp %h", outs, RstVal);
      end
      resb = 1'b1;
      auto_cyc = 1'b1;
   endtask

   task automatic test_lock();
      logic [11:0] exp;
      for (int i = 1; i <= 32; i++) begin
         tick();
         exp = (i == 32) ? IdleLck : RstVal;
         checks++;
         if (outs !== exp) begin
            errors++;
            $display("FAIL lock tick=%0d got %h exp %h", i, outs, exp);
         end
      end
   endtask

   task automatic test_cpu_read();
      logic [11:0] exp;
      cpu_req = 1'b1; cpu_rw = 1'b1; cpu_bank = 1'b0; cpu_uds = 1'b1; cpu_lds = 1'b1;
      repeat (16) tick();
      cpu_req = 1'b0; cpu_rw = 1'b0;  // captured already; must not matter
      for (int s = 0; s < 8; s++) begin
         exp = {(s >= 1 && s <= 6) ? 2'b10 : 2'b11,
                (s >= 4 && s <= 6) ? 2'b10 : 2'b11,
                (s >= 4 && s <= 6) ? 2'b10 : 2'b11,
                1'b1, (s >= 3 && s <= 6), (s == 6), 1'b0, 1'b0, 1'b1};
         checks++;
         if (outs !== exp) begin
            errors++;
            $display("FAIL cpu_read ph=%0d got %h exp %h", s, outs, exp);
         end
         tick();
      end
   endtask

   task automatic test_cpu_write();
      logic [11:0] exp;
      cpu_req = 1'b1; cpu_rw = 1'b0; cpu_bank = 1'b1; cpu_uds = 1'b1; cpu_lds = 1'b0;
      repeat (8) tick();
      cpu_req = 1'b0; cpu_rw = 1'b1; cpu_lds = 1'b1;
      for (int s = 0; s < 8; s++) begin
         exp = {(s >= 1 && s <= 6) ? 2'b01 : 2'b11,
                (s >= 4 && s <= 6) ? 2'b01 : 2'b11,
                2'b11,
                !(s >= 2 && s <= 6), (s >= 3 && s <= 6), (s == 6), 1'b0, 1'b0, 1'b1};
         checks++;
         if (outs !== exp) begin
            errors++;
            $display("FAIL cpu_write ph=%0d got %h exp %h", s, outs, exp);
         end
         tick();
      end
   endtask

   // Refresh interval elapses at the CPU boundary of the third period after
   // lock, so its video slot carries the refresh.
   task automatic test_refresh_idle();
      logic [11:0] exp;
      for (int s = 0; s < 8; s++) begin
         exp = {(s >= 1 && s <= 5) ? 2'b00 : 2'b11, 2'b11, 2'b11,
                1'b1, 1'b0, 1'b0, 1'b0, (s >= 1 && s <= 5), 1'b1};
         checks++;
         if (outs !== exp) begin
            errors++;
            $display("FAIL refresh_idle ph=%0d got %h exp %h", s + 8, outs, exp);
         end
         tick();
      end
   endtask

   // Refresh goes pending again at period 4; periods 4..10 defer it for video,
   // period 11 forces it, period 12 is video again.
   task automatic test_starve();
      logic [11:0] exp;
      int s;
      vid_req = 1'b1; vid_bank = 1'b0;
      for (int p = 3; p <= 12; p++) begin
         for (int ph = 0; ph < 16; ph++) begin
            s = ph - 8;
            if (ph < 8) exp = IdleLck;
            else if (p == 11)
               exp = {(s >= 1 && s <= 5) ? 2'b00 : 2'b11, 2'b11, 2'b11,
                      1'b1, 1'b0, 1'b0, 1'b0, (s >= 1 && s <= 5), 1'b1};
            else
               exp = {(s >= 1 && s <= 6) ? 2'b10 : 2'b11,
                      (s >= 4 && s <= 6) ? 2'b10 : 2'b11,
                      (s >= 4 && s <= 6) ? 2'b10 : 2'b11,
                      1'b1, (s >= 3 && s <= 6), 1'b0, (s == 6), 1'b0, 1'b1};
            checks++;
            if (outs !== exp) begin
               errors++;
               $display("FAIL starve period=%0d ph=%0d got %h exp %h", p, ph, outs, exp);
            end
            tick();
         end
      end
      vid_req = 1'b0;
   endtask

   task automatic test_lock_loss();
      logic [11:0] exp;
      cpu_req = 1'b1; cpu_rw = 1'b1; cpu_bank = 1'b0; cpu_uds = 1'b1; cpu_lds = 1'b1;
      repeat (16) tick();
      cpu_req = 1'b0;
      repeat (3) tick();
      exp = {2'b10, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      checks++;
      if (outs !== exp) begin
         errors++;
         $display("FAIL lock_loss_ph3 got %h exp %h", outs, exp);
      end
      inj = 1'b1;
      tick();
      checks++;
      if (outs !== RstVal) begin
         errors++;
         $display("FAIL lock_loss_cut got %h exp %h", outs, RstVal);
      end
      for (int i = 1; i <= 16; i++) begin
         tick();
         exp = (i == 16) ? IdleLck : RstVal;
         checks++;
         if (outs !== exp) begin
            errors++;
            $display("FAIL relock tick=%0d got %h exp %h", i, outs, exp);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [11:0] exp;
      cpu_req = 1'b1; cpu_rw = 1'b0; cpu_bank = 1'b0; cpu_uds = 1'b1; cpu_lds = 1'b1;
      repeat (16) tick();
      cpu_req = 1'b0;
      repeat (4) tick();
      exp = {2'b10, 2'b10, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      checks++;
      if (outs !== exp) begin
         errors++;
         $display("FAIL reset_mid_ph4 got %h exp %h", outs, exp);
      end
      resb = 1'b0;
      tick();
      checks++;
      if (outs !== RstVal) begin
         errors++;
         $display("FAIL reset_mid got %h exp %h", outs, RstVal);
      end
      resb = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         checks++;
         if (outs !== RstVal) begin
            errors++;
            $display("FAIL reset_mid_after tick=%0d got %h exp %h", i, outs, RstVal);
         end
      end
   endtask

   initial begin
      resb = 1'b0; cycsel_en = 1'b0;
      cpu_req = 1'b0; cpu_rw = 1'b1; cpu_bank = 1'b0; cpu_uds = 1'b0; cpu_lds = 1'b0;
      vid_req = 1'b0; vid_bank = 1'b0;
      test_reset();
      test_lock();
      test_cpu_read();
      test_cpu_write();
      test_refresh_idle();
      test_starve();
      test_lock_loss();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
